// File: rtl/bram2hs_pingpong_cast.sv
// Ping-pong BRAM-to-handshake cast: a producer fills one bank while the other drains as OUT_SIZE-lane batches.
// Define BRAM2HS_PINGPONG_PAD_EN to zero the unused lanes of a partial final batch.
module bram2hs_pingpong_cast #(
  parameter int OUT_SIZE   = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_RANGE = 100,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          address0,
  input  logic                           ce0,
  input  logic                           we0,
  input  logic [OUT_WIDTH-1:0]           d0,
  input  logic                           in_done,
  output logic                           in_ready,
  output logic [OUT_WIDTH-1:0]           data_out [OUT_SIZE],
  output logic [$clog2(OUT_SIZE+1)-1:0]  data_out_count,
  output logic                           data_out_last,
  output logic                           data_out_valid,
  input  logic                           data_out_ready
);
  localparam int NUM_BATCH = (ADDR_RANGE + OUT_SIZE - 1) / OUT_SIZE;
  localparam int CW        = $clog2(OUT_SIZE + 1);
  localparam int LW        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int BW        = (NUM_BATCH > 1) ? $clog2(NUM_BATCH) : 1;
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(ADDR_RANGE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(ADDR_RANGE - 1);
  localparam logic [LW-1:0]         LAST_LANE  = LW'(OUT_SIZE - 1);
  localparam logic [BW-1:0]         LAST_BATCH = BW'(NUM_BATCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [OUT_WIDTH-1:0]   mem0_r [ADDR_RANGE];
  logic [OUT_WIDTH-1:0]   mem1_r [ADDR_RANGE];
  logic [1:0]             full_r;
  logic                   wr_sel_r;
  logic                   rd_sel_r;
  logic [ADDR_WIDTH-1:0]  addr_cnt_r;
  logic [LW-1:0]          lane_cnt_r;
  logic [LW-1:0]          cap_lane_r;
  logic [BW-1:0]          batch_cnt_r;
  logic                   issue_r;
  logic                   cap_r;
  logic                   cap_final_r;
  logic [OUT_WIDTH-1:0]   rd_data_r;
  logic                   wr_en_s;
  logic                   done_s;
  logic                   rd_en_s;
  logic                   release_s;
  logic                   issue_final_s;

  assign in_ready      = ~full_r[wr_sel_r];
  assign wr_en_s       = ce0 & we0 & in_ready & ({1'b0, address0} < ADDR_LIMIT);
  assign done_s        = in_done & in_ready;
  assign rd_en_s       = (state_r == ST_FETCH) & issue_r;
  assign release_s     = (state_r == ST_HOLD) & data_out_ready & data_out_last;
  assign issue_final_s = (lane_cnt_r == LAST_LANE) | (addr_cnt_r == LAST_ADDR);

  // Bank status and pointers; completion and release target different banks so both may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r   <= 2'b00;
      wr_sel_r <= 1'b0;
      rd_sel_r <= 1'b0;
    end else begin
      if (done_s) begin
        full_r[wr_sel_r] <= 1'b1;
        wr_sel_r         <= ~wr_sel_r;
      end
      if (release_s) begin
        full_r[rd_sel_r] <= 1'b0;
        rd_sel_r         <= ~rd_sel_r;
      end
    end
  end

  // Bank storage with a registered read port; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s && !wr_sel_r) mem0_r[address0] <= d0;
    if (wr_en_s && wr_sel_r)  mem1_r[address0] <= d0;
    if (rd_en_s) rd_data_r <= rd_sel_r ? mem1_r[addr_cnt_r] : mem0_r[addr_cnt_r];
  end

  // Read FSM: issue reads, capture one cycle later into lanes, then hold the batch until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      addr_cnt_r     <= '0;
      lane_cnt_r     <= '0;
      cap_lane_r     <= '0;
      batch_cnt_r    <= '0;
      issue_r        <= 1'b0;
      cap_r          <= 1'b0;
      cap_final_r    <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_count <= '0;
      data_out_last  <= 1'b0;
      for (int i = 0; i < OUT_SIZE; i++) data_out[i] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (full_r[rd_sel_r]) begin
            state_r     <= ST_FETCH;
            addr_cnt_r  <= '0;
            lane_cnt_r  <= '0;
            batch_cnt_r <= '0;
            issue_r     <= 1'b1;
            cap_r       <= 1'b0;
          end
        end
        ST_FETCH: begin
          cap_r <= issue_r;
          if (issue_r) begin
            cap_lane_r  <= lane_cnt_r;
            cap_final_r <= issue_final_s;
            addr_cnt_r  <= addr_cnt_r + ADDR_WIDTH'(1);
            lane_cnt_r  <= issue_final_s ? '0 : lane_cnt_r + LW'(1);
            issue_r     <= ~issue_final_s;
          end
          if (cap_r) begin
            data_out[cap_lane_r] <= rd_data_r;
            if (cap_final_r) begin
`ifdef BRAM2HS_PINGPONG_PAD_EN
              for (int i = 0; i < OUT_SIZE; i++) begin
                if (i > int'(cap_lane_r)) data_out[i] <= '0;
              end
`endif
              state_r        <= ST_HOLD;
              data_out_valid <= 1'b1;
              data_out_count <= CW'(cap_lane_r) + CW'(1);
              data_out_last  <= (batch_cnt_r == LAST_BATCH);
            end
          end
        end
        ST_HOLD: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            data_out_count <= '0;
            data_out_last  <= 1'b0;
            if (data_out_last) begin
              state_r <= ST_IDLE;
            end else begin
              state_r     <= ST_FETCH;
              lane_cnt_r  <= '0;
              batch_cnt_r <= batch_cnt_r + BW'(1);
              issue_r     <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/bram2hs_pingpong_cast.md
Name: bram2hs_pingpong_cast

Overview:
Double-buffered BRAM-to-handshake cast. An HLS-style producer writes one frame of ADDR_RANGE elements through a BRAM write port and signals completion with in_done. The block streams the frame out as OUT_SIZE-element batches with valid/ready handshaking. Two internal banks let the producer fill frame N+1 while frame N drains. It sits between an HLS producer kernel and a handshake-based consumer.

Parameters:
OUT_SIZE, 8, elements per output batch (lanes).
OUT_WIDTH, 8, bits per element.
ADDR_RANGE, 100, elements per frame (bank depth).
ADDR_WIDTH, 7, producer address width; must satisfy 2**ADDR_WIDTH >= ADDR_RANGE.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
address0  input  ADDR_WIDTH  producer write address.
ce0  input  1  producer chip enable.
we0  input  1  producer write enable.
d0  input  OUT_WIDTH  producer write data.
in_done  input  1  single-cycle pulse: current write bank complete.
in_ready  output  1  write bank is empty; producer may write and may pulse in_done.
data_out  output  OUT_WIDTH x OUT_SIZE  unpacked batch, lane 0 = lowest address.
data_out_count  output  $clog2(OUT_SIZE+1)  number of valid lanes in the current batch.
data_out_last  output  1  current batch is the final batch of the frame.
data_out_valid  output  1  batch valid.
data_out_ready  input  1  consumer accepts the batch.

Behaviour:
- Reset (asynchronous on rst_n low): both banks EMPTY; wr_sel=0, rd_sel=0; read FSM IDLE; data_out all 0; data_out_valid=0; data_out_count=0; data_out_last=0. in_ready=1 once rst_n is high. Frame contents are discarded on reset mid-frame.
- Banks: two memories of ADDR_RANGE x OUT_WIDTH, each with a status bit EMPTY/FULL. Read latency is 1 cycle.
- Write side:
  - A write occurs when ce0 & we0 & in_ready; it stores d0 at address0 in bank wr_sel.
  - Writes while in_ready=0, or with address0 >= ADDR_RANGE, are dropped.
  - in_ready = (bank wr_sel EMPTY).
  - in_done while in_ready: bank wr_sel becomes FULL and wr_sel toggles. in_done while in_ready=0 is ignored.
  - A write and in_done in the same cycle: the write lands in the old bank.
- Read FSM, states IDLE / FETCH / HOLD:
  - IDLE: when bank rd_sel is FULL, clear addr_cnt and go to FETCH.
  - FETCH:
    - Issue one read per cycle at addr_cnt; capture data one cycle later into lane lane_cnt.
    - Stop issuing when lane_cnt reaches OUT_SIZE-1 or addr_cnt reaches ADDR_RANGE-1.
    - Enter HOLD after the final capture.
    - A full batch reaches valid OUT_SIZE+1 cycles after FETCH entry.
  - HOLD:
    - data_out_valid=1; data_out, count and last are stable until data_out_ready.
    - On handshake: if the batch was last, bank rd_sel becomes EMPTY, rd_sel toggles, go to IDLE. Otherwise reset lane_cnt and return to FETCH.
- Batch arithmetic:
  - NUM_BATCH = ceil(ADDR_RANGE/OUT_SIZE).
  - data_out_count = OUT_SIZE, except on the final batch of an imperfect partition: ADDR_RANGE - (NUM_BATCH-1)*OUT_SIZE.
  - data_out_last=1 only in HOLD of batch NUM_BATCH-1.
- Simultaneous events:
  - Writer completion of one bank and reader release of the other in the same cycle: both take effect.
  - Release of the bank wr_sel points to: in_ready rises the next cycle.
  - Both banks FULL: in_ready=0 until a release.
- data_out_valid never drops without a handshake.

Optional Feature:
BRAM2HS_PINGPONG_PAD_EN
- Defined: lanes >= data_out_count in a partial final batch are driven to 0.
- Undefined: those lanes retain stale values from the previous batch. Consumers must use data_out_count.

Test Plan:
- Reset, then write 0..99 to addresses 0..99 and pulse in_done (OUT_SIZE=8, ADDR_RANGE=100), with ready held 1 -> 13 batches. Batch k has lane i = 8k+i. Batch 12 has count=4, last=1, lanes 4..7 = 0 with PAD_EN.
- Same frame with ready deasserted for 5 cycles at each HOLD -> data_out, count and valid remain stable. No batch is lost or duplicated.
- Two frames back-to-back, the second written while the first drains -> in_ready stays 1 during the first drain. All 26 batches arrive in order.
- Three frames with consumer ready=0 -> in_ready=0 after the second in_done. Writes and in_done for the third frame are dropped until the first handshake release.
- ADDR_RANGE=16, OUT_SIZE=8 perfect partition -> 2 batches, both count=8, last only on the second.
- Assert rst_n low mid-FETCH -> valid=0 and data_out=0 immediately, in_ready=1 after release. A fresh frame streams correctly.
